// File: rtl/disparity_median_filter_if.sv
// rtl/disparity_median_filter_if.sv - pixel stream bundle between disparity calculator, median filter and consumer
interface disparity_median_filter_if;
    logic [31:0] disparity;
    logic [9:0]  row_in;
    logic [9:0]  col_in;
    logic        valid;
    logic [7:0]  disp_out;
    logic [9:0]  row_out;
    logic [9:0]  col_out;
    logic        valid_out;
    logic        frame_done;
    logic        sync_err;

    modport slave (
        input  disparity, row_in, col_in, valid,
        output disp_out, row_out, col_out, valid_out, frame_done, sync_err
    );

    modport master (
        output disparity, row_in, col_in, valid,
        input  disp_out, row_out, col_out, valid_out, frame_done, sync_err
    );
endinterface

// File: rtl/disparity_median_filter.sv
// rtl/disparity_median_filter.sv - 3x3 median post-filter with line buffers for the raster disparity stream
module disparity_median_filter #(
    parameter int unsigned IMG_W        = 640,
    parameter int unsigned IMG_H        = 480,
    parameter logic [7:0]  INVALID_CODE = 8'hFF
) (
    input  logic                     clk,
    input  logic                     rst,
    disparity_median_filter_if.slave dm
);
    localparam int unsigned AW      = $clog2(IMG_W);
    localparam logic [9:0]  W_LAST  = 10'(IMG_W - 1);
    localparam logic [9:0]  H_LAST  = 10'(IMG_H - 1);
    localparam logic [10:0] R_LAST  = 11'(IMG_H - 1);
    // The final flush bubble sits at row IMG_H+1, column 0
    localparam logic [10:0] R_FLUSH = 11'(IMG_H + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    typedef struct packed {
        logic       v;
        logic       pass;
        logic [9:0] row;
        logic [9:0] col;
        logic [7:0] ctr;
    } meta_t;

    function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [7:0] max3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    state_t               state_q, state_d;
    logic [9:0]           cnt_col_q, cnt_col_d;
    logic [10:0]          cnt_row_q, cnt_row_d;
    logic                 sync_err_q, sync_err_d;
    logic [2:0][2:0][7:0] win_q, win_d;
    meta_t                p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic [2:0][7:0]      lo_q, lo_d, md_q, md_d, hi_q, hi_d;
    logic [2:0][7:0]      s2_q, s2_d;
    logic [7:0]           s3_q, s3_d;
    logic [7:0]           disp_out_q, disp_out_d;
    logic [9:0]           row_out_q, row_out_d;
    logic [9:0]           col_out_q, col_out_d;
    logic                 valid_out_q, valid_out_d;
    logic                 frame_done_q, frame_done_d;

    logic                 accept;
    logic                 last_pix;
    logic                 trigger;
    logic [7:0]           pix;
    logic [9:0]           ctr_row, ctr_col;
    logic [AW-1:0]        lb_addr;
    logic [7:0]           lb_top, lb_mid;

    logic [7:0]           lb0_mem [IMG_W];
    logic [7:0]           lb1_mem [IMG_W];

    assign lb_addr = cnt_col_q[AW-1:0];
    assign lb_top  = lb0_mem[lb_addr];
    assign lb_mid  = lb1_mem[lb_addr];

    // Frame sequencing: decide whether this cycle accepts an index and advance the raster counters
    always_comb begin
        state_d    = state_q;
        cnt_col_d  = cnt_col_q;
        cnt_row_d  = cnt_row_q;
        sync_err_d = sync_err_q;
        accept     = 1'b0;
        pix        = (dm.disparity == 32'hFFFF_FFFF) ? INVALID_CODE : dm.disparity[7:0];
        last_pix   = (cnt_row_q == R_LAST) && (cnt_col_q == W_LAST);
        case (state_q)
            IDLE: begin
                if (dm.valid && (dm.row_in == 10'd0) && (dm.col_in == 10'd0)) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dm.valid) begin
                    accept = 1'b1;
                    if (({1'b0, dm.row_in} != cnt_row_q) || (dm.col_in != cnt_col_q)) begin
                        sync_err_d = 1'b1;
                    end
                    if (last_pix) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                accept = 1'b1;
                pix    = INVALID_CODE;
                if (dm.valid) begin
                    sync_err_d = 1'b1;
                end
                if (cnt_row_q == R_FLUSH) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            if (state_d == IDLE) begin
                cnt_col_d = 10'd0;
                cnt_row_d = 11'd0;
            end else if (cnt_col_q == W_LAST) begin
                cnt_col_d = 10'd0;
                cnt_row_d = cnt_row_q + 11'd1;
            end else begin
                cnt_col_d = cnt_col_q + 10'd1;
            end
        end
    end

    // Window shift and emission: the centre of the new window is always index n-(IMG_W+1)
    always_comb begin
        trigger = accept && ((cnt_row_q >= 11'd2) || ((cnt_row_q == 11'd1) && (cnt_col_q != 10'd0)));
        if (cnt_col_q == 10'd0) begin
            ctr_row = 10'(cnt_row_q - 11'd2);
            ctr_col = W_LAST;
        end else begin
            ctr_row = 10'(cnt_row_q - 11'd1);
            ctr_col = cnt_col_q - 10'd1;
        end
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb_top;
            win_d[1][2] = lb_mid;
            win_d[2][2] = pix;
        end
        p0_d      = '0;
        p0_d.v    = trigger;
        p0_d.row  = ctr_row;
        p0_d.col  = ctr_col;
        p0_d.pass = (ctr_row == 10'd0) || (ctr_row == H_LAST) || (ctr_col == 10'd0) || (ctr_col == W_LAST);
        p0_d.ctr  = win_d[1][1];
    end

    // Median network and output select; runs every cycle so it drains even while input stalls
    always_comb begin
        p1_d = p0_q;
        for (int r = 0; r < 3; r++) begin
            lo_d[r] = min3(win_q[r][0], win_q[r][1], win_q[r][2]);
            md_d[r] = med3(win_q[r][0], win_q[r][1], win_q[r][2]);
            hi_d[r] = max3(win_q[r][0], win_q[r][1], win_q[r][2]);
        end
        p2_d    = p1_q;
        s2_d[0] = max3(lo_q[0], lo_q[1], lo_q[2]);
        s2_d[1] = med3(md_q[0], md_q[1], md_q[2]);
        s2_d[2] = min3(hi_q[0], hi_q[1], hi_q[2]);
        p3_d    = p2_q;
        s3_d    = med3(s2_q[0], s2_q[1], s2_q[2]);

        valid_out_d  = p3_q.v;
        frame_done_d = p3_q.v && (p3_q.row == H_LAST) && (p3_q.col == W_LAST);
        disp_out_d   = disp_out_q;
        row_out_d    = row_out_q;
        col_out_d    = col_out_q;
        if (p3_q.v) begin
            row_out_d  = p3_q.row;
            col_out_d  = p3_q.col;
            disp_out_d = (p3_q.pass || (p3_q.ctr == INVALID_CODE)) ? p3_q.ctr : s3_q;
        end
    end

    // Control state, window, pipeline and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_col_q    <= '0;
            cnt_row_q    <= '0;
            sync_err_q   <= 1'b0;
            win_q        <= '0;
            p0_q         <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            p3_q         <= '0;
            lo_q         <= '0;
            md_q         <= '0;
            hi_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            disp_out_q   <= '0;
            row_out_q    <= '0;
            col_out_q    <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_col_q    <= cnt_col_d;
            cnt_row_q    <= cnt_row_d;
            sync_err_q   <= sync_err_d;
            win_q        <= win_d;
            p0_q         <= p0_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            p3_q         <= p3_d;
            lo_q         <= lo_d;
            md_q         <= md_d;
            hi_q         <= hi_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            disp_out_q   <= disp_out_d;
            row_out_q    <= row_out_d;
            col_out_q    <= col_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffers: lb1 holds the row above the incoming pixel, lb0 the row above that
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[lb_addr] <= pix;
            lb0_mem[lb_addr] <= lb1_mem[lb_addr];
        end
    end

    assign dm.disp_out   = disp_out_q;
    assign dm.row_out    = row_out_q;
    assign dm.col_out    = col_out_q;
    assign dm.valid_out  = valid_out_q;
    assign dm.frame_done = frame_done_q;
    assign dm.sync_err   = sync_err_q;
endmodule
